// File: rtl/bus_xfer_ctrl_if.sv
// Request and register-strobe bundle between the decoder/register file and the
// transfer sequencer.
interface bus_xfer_ctrl_if #(
   parameter int unsigned NREG = 4,
   parameter int unsigned SELW = 2
);
   logic            start;
   logic [SELW-1:0] src;
   logic [SELW-1:0] dst;
   logic            bus_sel;
   logic            src_imm;
   logic [7:0]      imm;

   logic [NREG-1:0] rd_data_en;
   logic [NREG-1:0] wr_data_en;
   logic [NREG-1:0] rd_addr_en;
   logic [NREG-1:0] wr_addr_en;
   logic            imm_oe;
   logic [7:0]      imm_q;
   logic            busy;
   logic            done;
   logic            err;

   // Sequencer side: takes requests, drives register strobes.
   modport master (
      input  start, src, dst, bus_sel, src_imm, imm,
      output rd_data_en, wr_data_en, rd_addr_en, wr_addr_en,
      output imm_oe, imm_q, busy, done, err
   );

   // Decoder / register-file side.
   modport slave (
      output start, src, dst, bus_sel, src_imm, imm,
      input  rd_data_en, wr_data_en, rd_addr_en, wr_addr_en,
      input  imm_oe, imm_q, busy, done, err
   );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register / immediate-to-register transfer sequencer: turns one
// request into drive-then-write strobes on the shared data or address bus.
module bus_xfer_ctrl #(
   parameter int unsigned NREG = 4,
   parameter int unsigned SELW = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   bus_xfer_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, DRIVE, WRITE, DONE, ERR} state_t;

   state_t          state;
   logic [SELW-1:0] src_q;
   logic [SELW-1:0] dst_q;
   logic            bus_sel_q;
   logic            src_imm_q;

   logic [NREG-1:0] rd_data_en_r;
   logic [NREG-1:0] wr_data_en_r;
   logic [NREG-1:0] rd_addr_en_r;
   logic [NREG-1:0] wr_addr_en_r;
   logic            imm_oe_r;
   logic [7:0]      imm_q_r;
   logic            busy_r;
   logic            done_r;
   logic            err_r;

   logic [NREG-1:0] src_oh_c;
   logic [NREG-1:0] dst_oh_c;

   assign src_oh_c = NREG'(1) << src_q;
   assign dst_oh_c = NREG'(1) << dst_q;

   // Outputs are registered from the state being left, so each state's strobes
   // appear for the cycle after that state was occupied.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         bus_sel_q    <= 1'b0;
         src_imm_q    <= 1'b0;
         rd_data_en_r <= '0;
         wr_data_en_r <= '0;
         rd_addr_en_r <= '0;
         wr_addr_en_r <= '0;
         imm_oe_r     <= 1'b0;
         imm_q_r      <= 8'h00;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         rd_data_en_r <= '0;
         wr_data_en_r <= '0;
         rd_addr_en_r <= '0;
         wr_addr_en_r <= '0;
         imm_oe_r     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  src_q     <= bus.src;
                  dst_q     <= bus.dst;
                  bus_sel_q <= bus.bus_sel;
                  src_imm_q <= bus.src_imm;
                  imm_q_r   <= bus.imm;
                  if ((bus.src_imm && bus.bus_sel) ||
                      (32'(bus.dst) >= NREG) ||
                      (!bus.src_imm && (32'(bus.src) >= NREG))) begin
                     state <= ERR;
                  end else if (!bus.src_imm && (bus.src == bus.dst)) begin
                     state <= DONE;
                  end else begin
                     state <= DRIVE;
                  end
               end
            end

            DRIVE, WRITE: begin
               busy_r <= 1'b1;
               if (src_imm_q)      imm_oe_r     <= 1'b1;
               else if (bus_sel_q) rd_addr_en_r <= src_oh_c;
               else                rd_data_en_r <= src_oh_c;
               // Write strobe only once the source has held the bus a full cycle.
               if (state == WRITE) begin
                  if (bus_sel_q) wr_addr_en_r <= dst_oh_c;
                  else           wr_data_en_r <= dst_oh_c;
               end
               state <= (state == DRIVE) ? WRITE : DONE;
            end

            DONE: begin
               done_r <= 1'b1;
               state  <= IDLE;
            end

            ERR: begin
               err_r <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rd_data_en = rd_data_en_r;
   assign bus.wr_data_en = wr_data_en_r;
   assign bus.rd_addr_en = rd_addr_en_r;
   assign bus.wr_addr_en = wr_addr_en_r;
   assign bus.imm_oe     = imm_oe_r;
   assign bus.imm_q      = imm_q_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.err        = err_r;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a 4-register file on shared buses around one DUT,
// plus a 3-register DUT for out-of-range selects.
module tb_bus_xfer_ctrl;
   localparam int unsigned SELW = 2;

   typedef enum int {K_MOVE, K_NOOP, K_ERR} kind_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bus_xfer_ctrl_if #(.NREG(4), .SELW(SELW)) bif4 ();
   bus_xfer_ctrl_if #(.NREG(3), .SELW(SELW)) bif3 ();

   bus_xfer_ctrl #(.NREG(4), .SELW(SELW)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bif4));
   bus_xfer_ctrl #(.NREG(3), .SELW(SELW)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bif3));

   int n_checks = 0;
   int n_pass   = 0;

   // Register file and bus wiring driven only by the DUT strobes
   logic [7:0] regs [4];
   logic [7:0] exp_regs [4];
   logic       load_en = 1'b0;
   logic [1:0] load_idx = 2'd0;
   logic [7:0] load_val = 8'h00;
   logic [7:0] dbus;
   logic [7:0] abus;

   always_comb begin
      dbus = 8'h00;
      abus = 8'h00;
      if (bif4.imm_oe) dbus = bif4.imm_q;
      for (int i = 0; i < 4; i++) begin
         if (bif4.rd_data_en[i]) dbus = regs[i];
         if (bif4.rd_addr_en[i]) abus = regs[i];
      end
   end

   always @(posedge clk) begin
      if (load_en) regs[load_idx] <= load_val;
      for (int i = 0; i < 4; i++) begin
         if (bif4.wr_data_en[i]) regs[i] <= dbus;
         if (bif4.wr_addr_en[i]) regs[i] <= abus;
      end
   end

   function automatic logic [19:0] get_out(input bit use3);
      if (use3)
         return {1'b0, bif3.rd_data_en, 1'b0, bif3.wr_data_en, 1'b0, bif3.rd_addr_en,
                 1'b0, bif3.wr_addr_en, bif3.imm_oe, bif3.busy, bif3.done, bif3.err};
      return {bif4.rd_data_en, bif4.wr_data_en, bif4.rd_addr_en, bif4.wr_addr_en,
              bif4.imm_oe, bif4.busy, bif4.done, bif4.err};
   endfunction

   function automatic kind_t classify(input int nreg, input int src, input int dst,
                                      input bit bus_sel, input bit src_imm);
      if (src_imm && bus_sel)      return K_ERR;
      if (dst >= nreg)             return K_ERR;
      if (!src_imm && src >= nreg) return K_ERR;
      if (!src_imm && src == dst)  return K_NOOP;
      return K_MOVE;
   endfunction

   // Expected outputs k cycles after the start edge, from the transfer timetable
   function automatic logic [19:0] exp_out(input kind_t kd, input int k, input int src,
                                           input int dst, input bit bus_sel, input bit src_imm);
      logic [3:0] rd_d, wr_d, rd_a, wr_a;
      logic       ioe, bsy, dn, er;
      rd_d = 4'd0; wr_d = 4'd0; rd_a = 4'd0; wr_a = 4'd0;
      ioe = 1'b0; bsy = 1'b0; dn = 1'b0; er = 1'b0;
      case (kd)
         K_ERR:  er = (k == 1);
         K_NOOP: dn = (k == 1);
         default: begin
            if (k == 1 || k == 2) begin
               bsy = 1'b1;
               if (src_imm)      ioe = 1'b1;
               else if (bus_sel) rd_a[src] = 1'b1;
               else              rd_d[src] = 1'b1;
            end
            if (k == 2) begin
               if (bus_sel) wr_a[dst] = 1'b1;
               else         wr_d[dst] = 1'b1;
            end
            dn = (k == 3);
         end
      endcase
      return {rd_d, wr_d, rd_a, wr_a, ioe, bsy, dn, er};
   endfunction

   task automatic drive(input bit use3, input bit st, input int src, input int dst,
                        input bit bs, input bit si, input logic [7:0] im);
      if (use3) begin
         bif3.start = st; bif3.src = SELW'(src); bif3.dst = SELW'(dst);
         bif3.bus_sel = bs; bif3.src_imm = si; bif3.imm = im;
      end else begin
         bif4.start = st; bif4.src = SELW'(src); bif4.dst = SELW'(dst);
         bif4.bus_sel = bs; bif4.src_imm = si; bif4.imm = im;
      end
   endtask

   task automatic load_reg(input int idx, input logic [7:0] v);
      load_en = 1'b1; load_idx = 2'(idx); load_val = v;
      @(negedge clk);
      load_en = 1'b0;
      exp_regs[idx] = v;
   endtask

   task automatic check_regs(input string tag);
      n_checks++;
      if ({regs[0], regs[1], regs[2], regs[3]} !==
          {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3]})
         $display("FAIL %s regs got %h %h %h %h want %h %h %h %h", tag,
                  regs[0], regs[1], regs[2], regs[3],
                  exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3]);
      else n_pass++;
   endtask

   task automatic check_idle(input bit use3, input string tag);
      n_checks++;
      if (get_out(use3) !== 20'h0) $display("FAIL %s idle outputs got %h want 00000", tag, get_out(use3));
      else n_pass++;
   endtask

   // One request from a negedge; junk = re-pulse start with other fields while busy
   task automatic run_xfer(input bit use3, input int src, input int dst, input bit bus_sel,
                           input bit src_imm, input logic [7:0] imm, input bit junk,
                           input string tag);
      kind_t      kd;
      int         len;
      logic [19:0] got, exp;
      kd  = classify(use3 ? 3 : 4, src, dst, bus_sel, src_imm);
      len = (kd == K_MOVE) ? 3 : 1;
      drive(use3, 1'b1, src, dst, bus_sel, src_imm, imm);
      @(negedge clk);
      for (int k = 1; k <= len; k++) begin
         drive(use3, junk, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom),
               1'($urandom), 8'($urandom));
         @(negedge clk);
         got = get_out(use3);
         exp = exp_out(kd, k, src, dst, bus_sel, src_imm);
         n_checks++;
         if (got !== exp) $display("FAIL %s cyc%0d outputs got %h want %h", tag, k, got, exp);
         else n_pass++;
         n_checks++;
         if (($countones(got[19:16]) + 32'(got[3]) > 1) || ($countones(got[11:8]) > 1) ||
             ($countones(got[15:12] | got[7:4]) > 1) || ((got[15:12] & got[7:4]) != 4'd0))
            $display("FAIL %s cyc%0d invariant outputs got %h", tag, k, got);
         else n_pass++;
         if (exp[3]) begin
            n_checks++;
            if ((use3 ? bif3.imm_q : bif4.imm_q) !== imm)
               $display("FAIL %s imm_q got %h want %h", tag, use3 ? bif3.imm_q : bif4.imm_q, imm);
            else n_pass++;
         end
      end
      drive(use3, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00);
      if (!use3) begin
         if (kd == K_MOVE) exp_regs[dst] = src_imm ? imm : exp_regs[src];
         check_regs(tag);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_idle(1'b0, "reset4");
         check_idle(1'b1, "reset3");
         n_checks++;
         if (bif4.imm_q !== 8'h00) $display("FAIL reset imm_q got %h want 00", bif4.imm_q);
         else n_pass++;
      end
      for (int i = 0; i < 4; i++) load_reg(i, 8'(8'h10 * i));
   endtask

   task automatic test_data_move();
      load_reg(1, 8'h5A);
      run_xfer(1'b0, 1, 2, 1'b0, 1'b0, 8'($urandom), 1'b0, "data_move");
   endtask

   task automatic test_imm_and_addr();
      run_xfer(1'b0, 2, 3, 1'b0, 1'b1, 8'hC3, 1'b0, "imm_load");
      run_xfer(1'b0, 3, 0, 1'b1, 1'b0, 8'h00, 1'b0, "addr_move");
   endtask

   task automatic test_reject_noop();
      run_xfer(1'b0, 0, 2, 1'b1, 1'b1, 8'h99, 1'b0, "err_imm_addr");
      run_xfer(1'b0, 1, 1, 1'b0, 1'b0, 8'h00, 1'b0, "noop");
      run_xfer(1'b0, 2, 2, 1'b1, 1'b0, 8'h00, 1'b0, "noop_addr");
   endtask

   task automatic test_busy_ignore();
      load_reg(0, 8'hE7);
      run_xfer(1'b0, 0, 3, 1'b0, 1'b0, 8'h00, 1'b1, "busy_first");
      run_xfer(1'b0, 3, 1, 1'b1, 1'b0, 8'h00, 1'b0, "after_done");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3, 0) == 0) load_reg($urandom_range(3, 0), 8'($urandom));
         if ($urandom_range(3, 0) == 0) begin
            @(negedge clk);
            check_idle(1'b0, "gap");
         end
         run_xfer(1'b0, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom),
                  1'($urandom), 8'($urandom), 1'($urandom), "random");
      end
   endtask

   task automatic test_reset_mid();
      load_reg(1, 8'h77);
      load_reg(2, 8'h11);
      drive(1'b0, 1'b1, 1, 2, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle(1'b0, "rst_mid_edge");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle(1'b0, "rst_mid_after");
      end
      check_regs("rst_mid_regs");
   endtask

   task automatic test_nreg3();
      run_xfer(1'b1, 0, 3, 1'b0, 1'b0, 8'h00, 1'b0, "n3_dst3");
      run_xfer(1'b1, 3, 1, 1'b0, 1'b0, 8'h00, 1'b0, "n3_src3");
      run_xfer(1'b1, 0, 2, 1'b1, 1'b0, 8'h00, 1'b0, "n3_move");
      run_xfer(1'b1, 1, 3, 1'b0, 1'b1, 8'h42, 1'b0, "n3_imm_dst3");
      run_xfer(1'b1, 3, 2, 1'b0, 1'b1, 8'h42, 1'b0, "n3_imm_move");
      run_xfer(1'b1, 2, 2, 1'b0, 1'b0, 8'h00, 1'b0, "n3_noop");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_data_move();
      test_imm_and_addr();
      test_reject_noop();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_nreg3();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
